mips_bus_arbiter: RTL

- Parametrised memory-port successor for the CPU core.
- Replaces the single-cycle instruction/data SRAM ports with two handshaked requester channels (instruction, data).
- Arbitrates both channels onto one shared request/grant/response bus and adds configurable arbitration and a timeout/bus-error path.
- Sits between the core's fetch/mem stages and the external memory system; the core stalls while its channel's req is high and done has not yet pulsed.

---
 rtl/mips_bus_pkg.sv | 20 ++
 rtl/mips_bus_arbiter_if.sv | 41 ++++
 rtl/mips_bus_rr_pick.sv | 24 ++
 rtl/mips_bus_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the core memory-port arbiter.
// State, channel and arbitration-mode encodings.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RESP,
    ST_DONE
  } state_e;

  typedef enum logic {
    CH_INST = 1'b0,
    CH_DATA = 1'b1
  } ch_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Shared request/grant/response memory bus.
// The arbiter is the master, the memory system the slave.
interface mips_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  localparam int BE_W = DATA_W / 8;

  logic              bus_req;
  logic              bus_we;
  logic [BE_W-1:0]   bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_be,
    output bus_addr,
    output bus_wdata,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_be,
    input  bus_addr,
    input  bus_wdata,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );

endinterface

// File: rtl/mips_bus_rr_pick.sv
// Two-way request picker: fixed (data first) or round-robin.
// Grant bit index equals the channel encoding.
module mips_bus_rr_pick
  import mips_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       mode_i,
  input  ch_e        last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11):
        gnt_o = (mode_i && last_i == CH_DATA)
                ? 2'b01 : 2'b10;
      (req_i == 2'b10): gnt_o = 2'b10;
      (req_i == 2'b01): gnt_o = 2'b01;
      default:          gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Instruction/data channel arbiter onto one shared bus,
// with round-robin option and a timeout error completion.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255,
  localparam int BE_W    = DATA_W / 8,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  mips_bus_arbiter_if.master bus,
  output logic              busy
);

  state_e            state_q;
  ch_e               owner_q, last_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_we_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_done_q, d_done_q;
  logic              i_err_q, d_err_q;
  logic [1:0]        pick;
  logic              tmo, rsp_ok, abort;
  logic [DATA_W-1:0] fin_data;

  mips_bus_rr_pick u_pick (
    .req_i  ({d_req, i_req}),
    .mode_i (ARB_MODE == ARB_RR),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Progress (gnt/rvalid) wins over a timeout on the same cycle.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    tmo      = (cnt_d == CNT_W'(TIMEOUT));
    rsp_ok   = (state_q == ST_RESP) && bus.bus_rvalid;
    abort    = tmo && (
                 ((state_q == ST_ADDR) && !bus.bus_gnt) ||
                 ((state_q == ST_RESP) && !bus.bus_rvalid));
    fin_data = (abort || bus_we_q) ? '0 : bus.bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= CH_INST;
      last_q      <= CH_DATA;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|pick) begin
            owner_q     <= ch_e'(pick[1]);
            last_q      <= ch_e'(pick[1]);
            bus_req_q   <= 1'b1;
            bus_we_q    <= pick[1] & d_we;
            bus_be_q    <= pick[1] ? d_be : '1;
            bus_addr_q  <= pick[1] ? d_addr : i_addr;
            bus_wdata_q <= pick[1] ? d_wdata : '0;
            cnt_q       <= '0;
            state_q     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          cnt_q <= cnt_d;
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: cnt_q <= cnt_d;
        ST_DONE: state_q <= ST_IDLE;
      endcase
      if (rsp_ok || abort) begin
        state_q   <= ST_DONE;
        bus_req_q <= 1'b0;
        if (owner_q == CH_DATA) begin
          d_done_q  <= 1'b1;
          d_err_q   <= abort;
          d_rdata_q <= fin_data;
        end else begin
          i_done_q  <= 1'b1;
          i_err_q   <= abort;
          i_rdata_q <= fin_data;
        end
      end
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_done        = i_done_q;
  assign d_done        = d_done_q;
  assign i_err         = i_err_q;
  assign d_err         = d_err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
